// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the imem (read-only) and dmem
// (read/write) ports. Handles sub-word alignment and arbitrates between the ports.
module ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter bit PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_valid,
  output logic              imem_ready,
  input  logic [31:0]       imem_addr,
  output logic [31:0]       imem_rdata,
  input  logic              dmem_valid,
  output logic              dmem_ready,
  input  logic [31:0]       dmem_addr,
  input  logic [3:0]        dmem_wmask,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [3:0]        ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  state_t      state_q, state_d;
  logic        last_dmem_q, last_dmem_d;
  logic        fault_q, fault_d;
  logic [1:0]  off_q, off_d;
  logic        oob_q, oob_d;

  logic        gnt_dmem;
  logic        in_range;
  logic        grant;
  logic        dwrite;
  logic        unused_imem_bits;

  assign unused_imem_bits = ^{imem_addr[31:ADDR_W+2], imem_addr[1:0]};

  // On a tie, dmem wins under fixed priority or when imem went last.
  assign gnt_dmem = dmem_valid && (!imem_valid || PRIORITY || !last_dmem_q);
  assign in_range = (dmem_addr >> (ADDR_W + 2)) == 32'd0;
  assign grant    = reset && (state_q == IDLE) && (imem_valid || dmem_valid);
  assign dwrite   = grant && gnt_dmem && (dmem_wmask != 4'd0) && in_range;

  always_comb begin
    state_d     = state_q;
    last_dmem_d = last_dmem_q;
    fault_d     = fault_q;
    off_d       = off_q;
    oob_d       = oob_q;
    case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          state_d     = gnt_dmem ? RESP_D : RESP_I;
          last_dmem_d = gnt_dmem;
          if (gnt_dmem) begin
            off_d = dmem_addr[1:0];
            oob_d = !in_range;
            if (!in_range) fault_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_dmem_q <= 1'b1;
      fault_q     <= 1'b0;
      off_q       <= 2'd0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dmem_q <= last_dmem_d;
      fault_q     <= fault_d;
      off_q       <= off_d;
      oob_q       <= oob_d;
    end
  end

  always_comb begin
    ram_addr   = gnt_dmem ? dmem_addr[ADDR_W+1:2] : imem_addr[ADDR_W+1:2];
    ram_wen    = dwrite;
    ram_wmask  = 4'd0;
    ram_wdata  = 32'd0;
    if (dwrite) begin
      ram_wmask = dmem_wmask << dmem_addr[1:0];
      ram_wdata = dmem_wdata << {dmem_addr[1:0], 3'b000};
    end
    imem_ready = reset && (state_q == RESP_I);
    dmem_ready = reset && (state_q == RESP_D);
    imem_rdata = imem_ready ? ram_rdata : 32'd0;
    // Out-of-range accesses still complete but return zero.
    dmem_rdata = (dmem_ready && !oob_q) ? (ram_rdata >> {off_q, 3'b000}) : 32'd0;
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_valid, dmem_valid;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        imem_ready, dmem_ready, fault;
  logic [31:0] imem_rdata, dmem_rdata, ram_wdata, ram_rdata;
  logic [13:0] ram_addr;
  logic        ram_wen;
  logic [3:0]  ram_wmask;

  // Second instance with fixed dmem priority; only grant order is observed.
  logic        p1_iv, p1_dv;
  logic [3:0]  p1_wmask = 4'd0;
  logic [31:0] p1_rdata_in = 32'd0;
  logic        p1_iready, p1_dready, p1_wen, p1_fault;
  logic [31:0] p1_irdata, p1_drdata, p1_wdata;
  logic [13:0] p1_addr;
  logic [3:0]  p1_wm;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen)
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  ram_arbiter #(.ADDR_W(14), .PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fault(fault)
  );

  ram_arbiter #(.ADDR_W(14), .PRIORITY(1'b1)) dut_p1 (
    .clk(clk), .reset(reset),
    .imem_valid(p1_iv), .imem_ready(p1_iready), .imem_addr(imem_addr), .imem_rdata(p1_irdata),
    .dmem_valid(p1_dv), .dmem_ready(p1_dready), .dmem_addr(dmem_addr),
    .dmem_wmask(p1_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(p1_drdata),
    .ram_addr(p1_addr), .ram_wen(p1_wen), .ram_wmask(p1_wm), .ram_wdata(p1_wdata),
    .ram_rdata(p1_rdata_in), .fault(p1_fault)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; imem_valid = 1'b1; dmem_valid = 1'b1;
    imem_addr = 32'h10; dmem_addr = 32'h100; dmem_wmask = 4'hF; dmem_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", ram_wen); end
    checks++; if ({imem_ready, dmem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {imem_ready, dmem_ready}); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    checks++; if ({imem_rdata, dmem_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {imem_rdata, dmem_rdata}); end
    reset = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0; dmem_wmask = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_imem_read();
    imem_valid = 1'b1; imem_addr = 32'h0000_0010;
    #1;
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL imem_ram_addr got %h exp 4", ram_addr); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL imem_wen got %b exp 0", ram_wen); end
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || dmem_ready !== 1'b0) begin errors++; $display("FAIL imem_ready got %b%b exp 10", imem_ready, dmem_ready); end
    checks++; if (imem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imem_rdata got %h exp deadbeef", imem_rdata); end
    imem_valid = 1'b0;
    @(negedge clk);
    checks++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL imem_ready_low got %b exp 0", imem_ready); end
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    imem_addr = 32'h10; dmem_addr = 32'h20; dmem_wmask = 4'd0;
    imem_valid = 1'b1; dmem_valid = 1'b1; p1_iv = 1'b1; p1_dv = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (imem_ready !== (c % 4 == 1) || dmem_ready !== (c % 4 == 3)) begin
        errors++; $display("FAIL rr_cycle%0d got i%b d%b exp i%b d%b", c, imem_ready, dmem_ready, c % 4 == 1, c % 4 == 3);
      end
      checks++;
      if (p1_iready !== 1'b0 || p1_dready !== (c % 2 == 1)) begin
        errors++; $display("FAIL prio_cycle%0d got i%b d%b exp i0 d%b", c, p1_iready, p1_dready, c % 2 == 1);
      end
    end
    imem_valid = 1'b0; dmem_valid = 1'b0; p1_iv = 1'b0; p1_dv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_store_load();
    dmem_valid = 1'b1; dmem_addr = 32'h103; dmem_wmask = 4'b0001; dmem_wdata = 32'h0000_00AB;
    #1;
    checks++; if (ram_addr !== 14'h40) begin errors++; $display("FAIL bst_addr got %h exp 40", ram_addr); end
    checks++; if (ram_wen !== 1'b1 || ram_wmask !== 4'b1000) begin errors++; $display("FAIL bst_wen_mask got %b %b exp 1 1000", ram_wen, ram_wmask); end
    checks++; if (ram_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL bst_wdata got %h exp ab000000", ram_wdata); end
    @(negedge clk);
    checks++; if (dmem_ready !== 1'b1) begin errors++; $display("FAIL bst_ready got %b exp 1", dmem_ready); end
    dmem_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem[14'h40] !== 32'hAB22_3344) begin errors++; $display("FAIL bst_mem got %h exp ab223344", mem[14'h40]); end
    dmem_valid = 1'b1; dmem_wmask = 4'd0;
    #1;
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL bld_wen got %b exp 0", ram_wen); end
    @(negedge clk);
    checks++; if (dmem_ready !== 1'b1 || dmem_rdata !== 32'h0000_00AB) begin errors++; $display("FAIL bld_rdata got %b %h exp 1 000000ab", dmem_ready, dmem_rdata); end
    dmem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halfword_store();
    dmem_valid = 1'b1; dmem_addr = 32'h102; dmem_wmask = 4'b0011; dmem_wdata = 32'h0000_1234;
    #1;
    checks++; if (ram_wen !== 1'b1 || ram_wmask !== 4'b1100) begin errors++; $display("FAIL hst_wen_mask got %b %b exp 1 1100", ram_wen, ram_wmask); end
    checks++; if (ram_wdata !== 32'h1234_0000) begin errors++; $display("FAIL hst_wdata got %h exp 12340000", ram_wdata); end
    @(negedge clk);
    dmem_valid = 1'b0;
    @(negedge clk);
    dmem_valid = 1'b1; dmem_wmask = 4'd0;
    @(negedge clk);
    checks++; if (dmem_ready !== 1'b1 || dmem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL hld_rdata got %b %h exp 1 00001234", dmem_ready, dmem_rdata); end
    dmem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    dmem_valid = 1'b1; dmem_addr = 32'h0001_0000; dmem_wmask = 4'hF; dmem_wdata = 32'h5555_5555;
    #1;
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL oob_wen got %b exp 0", ram_wen); end
    @(negedge clk);
    checks++; if (dmem_ready !== 1'b1 || dmem_rdata !== 32'd0) begin errors++; $display("FAIL oob_resp got %b %h exp 1 0", dmem_ready, dmem_rdata); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL oob_fault got %b exp 1", fault); end
    dmem_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL oob_mem got %h exp cafef00d", mem[0]); end
    dmem_valid = 1'b1; dmem_addr = 32'h0; dmem_wmask = 4'd0;
    @(negedge clk);
    checks++; if (dmem_rdata !== 32'hCAFE_F00D || fault !== 1'b1) begin errors++; $display("FAIL oob_sticky got %h %b exp cafef00d 1", dmem_rdata, fault); end
    dmem_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL oob_clear got %b exp 0", fault); end
  endtask

  task automatic test_reset_mid_txn();
    dmem_valid = 1'b1; dmem_addr = 32'h20; dmem_wmask = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dmem_ready !== 1'b0 || dmem_rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_ready got %b %h exp 0 0", dmem_ready, dmem_rdata); end
    @(negedge clk);
    reset = 1'b1; dmem_valid = 1'b0;
    checks++; if ({imem_ready, dmem_ready} !== 2'b00) begin errors++; $display("FAIL mid_rst_idle got %b exp 00", {imem_ready, dmem_ready}); end
    imem_valid = 1'b1; dmem_valid = 1'b1; imem_addr = 32'h10;
    #1;
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL mid_rst_tie_addr got %h exp 4", ram_addr); end
    @(negedge clk);
    checks++; if (imem_ready !== 1'b1 || dmem_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_tie got %b%b exp 10", imem_ready, dmem_ready); end
    imem_valid = 1'b0; dmem_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[0]     = 32'hCAFE_F00D;
    mem[4]     = 32'hDEAD_BEEF;
    mem[8]     = 32'h0BAD_F00D;
    mem[14'h40] = 32'h1122_3344;
    reset = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0; p1_iv = 1'b0; p1_dv = 1'b0;
    imem_addr = 32'd0; dmem_addr = 32'd0; dmem_wmask = 4'd0; dmem_wdata = 32'd0;
    test_reset();
    test_imem_read();
    test_round_robin();
    test_byte_store_load();
    test_halfword_store();
    test_out_of_range();
    test_reset_mid_txn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency, byte enables) between the CPU instruction port (read-only) and data port (read/write).
- Sits between the minaret core's imem/dmem valid/ready interfaces and the RAM macro, replacing a dual-port RAM.
- Handles sub-word alignment on the data port and arbitrates between the two ports.

Parameters:
- ADDR_W, 14, RAM word-address width; RAM spans 2^(ADDR_W+2) bytes starting at byte 0.
- PRIORITY, 0, 0 = round-robin between ports, 1 = fixed dmem priority.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-low (reset==0 resets)
- imem_valid  input  1  instruction fetch request
- imem_ready  output  1  one-cycle completion pulse, imem_rdata valid
- imem_addr  input  32  byte address, word-aligned
- imem_rdata  output  32  fetched word
- dmem_valid  input  1  data request
- dmem_ready  output  1  one-cycle completion pulse
- dmem_addr  input  32  byte address
- dmem_wmask  input  4  byte write mask, LSB-aligned; 0 = read
- dmem_wdata  input  32  LSB-aligned store data
- dmem_rdata  output  32  load data, shifted to LSB
- ram_addr  output  ADDR_W  RAM word address
- ram_wen  output  1  RAM write enable
- ram_wmask  output  4  RAM byte enables
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM read data, valid the cycle after the address
- fault  output  1  sticky; a dmem access fell outside the RAM range

Behaviour:
- Protocol: a requester holds valid, addr, wmask and wdata stable until it sees ready. Ready is a single-cycle pulse. The block never asserts ready without a pending valid.
- States:
  - IDLE
  - RESP_I: imem response cycle
  - RESP_D: dmem response cycle
- IDLE:
  - If any valid, pick the grantee combinationally. ram_addr is driven from the grantee's addr[ADDR_W+1:2] in this same cycle.
  - Next state is RESP_I or RESP_D. Record last_grant.
  - If no valid, stay in IDLE. ram_addr is don't-care; ram_wen=0.
- Grant with both valid:
  - PRIORITY=0: grant the port not named in last_grant.
  - PRIORITY=1: always grant dmem.
  - last_grant resets to dmem, so the first tie goes to imem.
- RESP_I: imem_ready=1, imem_rdata=ram_rdata. Next state is IDLE.
- RESP_D: dmem_ready=1, dmem_rdata=ram_rdata >> (off*8), where off is dmem_addr[1:0] latched in the grant cycle. Next state is IDLE.
- Latency and throughput: valid-to-ready is 1 cycle when granted immediately, so ready arrives on the clock after grant. Maximum throughput is 1 transaction per 2 cycles. A requester keeping valid high through its ready cycle is re-arbitrated in the following IDLE cycle.
- dmem write (grant cycle only, wmask≠0, in range):
  - ram_wen=1
  - ram_wmask = (wmask << off)[3:0]; bits shifted past bit 3 are dropped
  - ram_wdata = wdata << (off*8), truncated to 32 bits
  - RESP_D still pulses dmem_ready; dmem_rdata is don't-care.
- ram_wen=0 in every other cycle, including all imem grants.
- Range check:
  - A dmem address ≥ 2^(ADDR_W+2) is still granted and completes in RESP_D, but with ram_wen=0 and dmem_rdata=0.
  - fault is set on the grant cycle and stays set until reset.
  - imem addresses are truncated, not checked.
- Reset (reset==0 at a clock edge):
  - state=IDLE, last_grant=dmem, fault=0, latched offset=0.
  - Outputs while in reset: imem_ready=0, dmem_ready=0, ram_wen=0 (combinationally gated by reset), rdata outputs=0.
- Reset mid-transaction drops the in-flight response; no ready is issued for it. Requesters must re-present after reset.

Test Plan:
1. imem_valid=1, imem_addr=0x0000_0010, RAM word 4=0xDEADBEEF → ram_addr=4 that cycle; next cycle imem_ready=1 and imem_rdata=0xDEADBEEF; ready low the following cycle.
2. First cycle after reset, both valid, PRIORITY=0, held continuously → grants alternate imem, dmem, imem, dmem. Ready pulses on cycles 1, 3, 5, 7, never both in the same cycle. With PRIORITY=1, only dmem is ever granted.
3. Byte store: dmem_addr=0x103, wmask=0001, wdata=0x000000AB → ram_addr=0x40, ram_wen=1, ram_wmask=1000, ram_wdata=0xAB000000. Then a load from 0x103 → dmem_rdata=0x000000AB in the low byte (full word shifted right 24).
4. Halfword store: dmem_addr=0x102, wmask=0011, wdata=0x1234 → ram_wmask=1100, ram_wdata=0x12340000.
5. dmem_addr=0x0001_0000 with ADDR_W=14, wmask=1111 → ram_wen never 1; dmem_ready pulses with dmem_rdata=0; fault=1 and stays 1 after later good accesses; reset clears it.
6. Assert reset (0) in the RESP_D cycle of a pending load → dmem_ready=0 that cycle. State is IDLE afterwards, and the next tie goes to imem.
